// File: rtl/wsg_audio_post.sv
// Post-processor for the wave sound generator mix: resample, DC block, lowpass,
// power-of-two gain with saturation, 16-bit signed output with a valid strobe.
module wsg_audio_post #(
    parameter int unsigned DIV      = 1024,
    parameter int unsigned DC_SHIFT = 10,
    parameter int unsigned LP_SHIFT = 2
) (
    input  logic               CLK24M,
    input  logic               RESET_N,
    input  logic [7:0]         SIN,
    input  logic               MUTE,
    input  logic [1:0]         VOL,
    output logic signed [15:0] AOUT,
    output logic               AVALID
);

    localparam int unsigned CNT_W = 16;
    localparam int unsigned XW    = 16;
    localparam int unsigned DCW   = 20;
    localparam int unsigned LDW   = 21;
    localparam int unsigned SW    = 22;
    localparam int unsigned GW    = 23;

    localparam logic signed [SW-1:0] DC_MAX = 22'sd524287;
    localparam logic signed [SW-1:0] DC_MIN = -22'sd524288;
    localparam logic signed [GW-1:0] G_MAX  = 23'sd32767;
    localparam logic signed [GW-1:0] G_MIN  = -23'sd32768;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_DC   = 3'd1,
        ST_LPF  = 3'd2,
        ST_GAIN = 3'd3,
        ST_OUT  = 3'd4
    } state_t;

    state_t state, state_nx_c;

    logic [CNT_W-1:0]   cnt;
    logic               tick_c;
    logic               cap_en_c, dc_en_c, lp_en_c, gain_en_c, out_en_c;

    logic signed [XW-1:0]  x, x_prev, x_cap_c;
    logic signed [DCW-1:0] dc_y, dc_sat_c;
    logic signed [SW-1:0]  dc_sum_c;
    logic signed [DCW-1:0] lp, lp_nx_c;
    logic signed [LDW-1:0] lp_diff_c;
    logic signed [GW-1:0]  gain_c;
    logic signed [XW-1:0]  g, g_sat_c;

    // Sample-period divider
    assign tick_c = (cnt == CNT_W'(DIV - 1));

    always_ff @(posedge CLK24M or negedge RESET_N) begin
        if (!RESET_N)    cnt <= '0;
        else if (tick_c) cnt <= '0;
        else             cnt <= cnt + CNT_W'(1);
    end

    always_ff @(posedge CLK24M or negedge RESET_N) begin
        if (!RESET_N) state <= ST_IDLE;
        else          state <= state_nx_c;
    end

    always_comb begin
        state_nx_c = state;
        case (state)
            ST_IDLE: if (tick_c) state_nx_c = ST_DC;
            ST_DC:   state_nx_c = ST_LPF;
            ST_LPF:  state_nx_c = ST_GAIN;
            ST_GAIN: state_nx_c = ST_OUT;
            ST_OUT:  state_nx_c = ST_IDLE;
            default: state_nx_c = ST_IDLE;
        endcase
    end

    // One datapath step enabled per state
    always_comb begin
        cap_en_c  = 1'b0;
        dc_en_c   = 1'b0;
        lp_en_c   = 1'b0;
        gain_en_c = 1'b0;
        out_en_c  = 1'b0;
        case (state)
            ST_IDLE: cap_en_c  = tick_c;
            ST_DC:   dc_en_c   = 1'b1;
            ST_LPF:  lp_en_c   = 1'b1;
            ST_GAIN: gain_en_c = 1'b1;
            ST_OUT:  out_en_c  = 1'b1;
            default: ;
        endcase
    end

    // Offset-binary to signed, scaled to full 16-bit range
    assign x_cap_c = {~SIN[7], SIN[6:0], 8'h00};

    always_comb begin
        dc_sum_c = SW'(x) - SW'(x_prev) + SW'(dc_y) - SW'(dc_y >>> DC_SHIFT);
        if (dc_sum_c > DC_MAX)      dc_sat_c = DCW'(DC_MAX);
        else if (dc_sum_c < DC_MIN) dc_sat_c = DCW'(DC_MIN);
        else                        dc_sat_c = DCW'(dc_sum_c);
    end

    // Convex update: the truncated sum always lands inside the 20-bit range
    always_comb begin
        lp_diff_c = LDW'(dc_y) - LDW'(lp);
        lp_nx_c   = lp + DCW'(lp_diff_c >>> LP_SHIFT);
    end

    always_comb begin
        gain_c = GW'(lp) <<< VOL;
        if (gain_c > G_MAX)      g_sat_c = XW'(G_MAX);
        else if (gain_c < G_MIN) g_sat_c = XW'(G_MIN);
        else                     g_sat_c = XW'(gain_c);
    end

    always_ff @(posedge CLK24M or negedge RESET_N) begin
        if (!RESET_N) begin
            x      <= '0;
            x_prev <= '0;
            dc_y   <= '0;
            lp     <= '0;
            g      <= '0;
            AOUT   <= '0;
            AVALID <= 1'b0;
        end else begin
            AVALID <= out_en_c;
            if (cap_en_c) x <= x_cap_c;
            if (dc_en_c) begin
                dc_y   <= dc_sat_c;
                x_prev <= x;
            end
            if (lp_en_c)   lp <= lp_nx_c;
            if (gain_en_c) g  <= g_sat_c;
            if (out_en_c)  AOUT <= MUTE ? '0 : g;
        end
    end

endmodule

// File: tb/tb_wsg_audio_post.sv
// Directed bench for wsg_audio_post: a DIV=1024 instance for sample timing and
// a DIV=8 instance for filter/gain/mute/reset behaviour over many samples.
module tb_wsg_audio_post;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst_n;
    logic [7:0]         sin, sin_f;
    logic               mute, mute_f;
    logic [1:0]         vol, vol_f;
    logic signed [15:0] aout, aout_f;
    logic               avalid, avalid_f;

    int n_cmp = 0;
    int n_bad = 0;

    wsg_audio_post #(.DIV(1024), .DC_SHIFT(10), .LP_SHIFT(2)) dut (
        .CLK24M(clk), .RESET_N(rst_n), .SIN(sin), .MUTE(mute), .VOL(vol),
        .AOUT(aout), .AVALID(avalid)
    );

    wsg_audio_post #(.DIV(8), .DC_SHIFT(10), .LP_SHIFT(2)) dut_f (
        .CLK24M(clk), .RESET_N(rst_n), .SIN(sin_f), .MUTE(mute_f), .VOL(vol_f),
        .AOUT(aout_f), .AVALID(avalid_f)
    );

    task automatic apply_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Waits (bounded) for the next AVALID of the fast instance
    task automatic wait_sample(output logic signed [15:0] v, output bit ok);
        int i;
        ok = 1'b0;
        v  = '0;
        i  = 0;
        while (!ok && i < 40) begin
            @(negedge clk);
            if (avalid_f) begin
                v  = aout_f;
                ok = 1'b1;
            end
            i++;
        end
    endtask

    task automatic test_reset();
        sin = 8'h80; mute = 1'b0; vol = 2'd0;
        sin_f = 8'h80; mute_f = 1'b0; vol_f = 2'd0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (aout !== 16'sd0 || avalid !== 1'b0 || aout_f !== 16'sd0 || avalid_f !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_state: aout=%0d avalid=%0b aout_f=%0d avalid_f=%0b want 0/0/0/0",
                     aout, avalid, aout_f, avalid_f);
        end
    endtask

    task automatic test_sample_timing();
        bit exp_v;
        sin = 8'h80; mute = 1'b0; vol = 2'd0;
        apply_reset();
        for (int n = 1; n <= 3080; n++) begin
            @(negedge clk);
            exp_v = (n >= 1028) && (((n - 1028) % 1024) == 0);
            n_cmp++;
            if (avalid !== exp_v || aout !== 16'sd0) begin
                n_bad++;
                $display("FAIL timing edge %0d: avalid=%0b aout=%0d want avalid=%0b aout=0",
                         n, avalid, aout, exp_v);
            end
        end
    endtask

    task automatic test_step_and_decay();
        logic signed [15:0] v, prev;
        bit ok, falling;
        sin_f = 8'hFF; mute_f = 1'b0; vol_f = 2'd0;
        apply_reset();
        wait_sample(v, ok);
        n_cmp++;
        if (!ok || v !== 16'sd8128) begin
            n_bad++; $display("FAIL step_s1: got %0d ok=%0b want 8128", v, ok);
        end
        wait_sample(v, ok);
        n_cmp++;
        if (!ok || v !== 16'sd14216) begin
            n_bad++; $display("FAIL step_s2: got %0d ok=%0b want 14216", v, ok);
        end
        wait_sample(v, ok);
        n_cmp++;
        if (!ok || v !== 16'sd18774) begin
            n_bad++; $display("FAIL step_s3: got %0d ok=%0b want 18774", v, ok);
        end
        prev    = v;
        falling = 1'b0;
        for (int s = 4; s <= 5000; s++) begin
            wait_sample(v, ok);
            n_cmp++;
            if (!ok || $isunknown(v) || v < 0 || (falling && v > prev)) begin
                n_bad++;
                $display("FAIL decay sample %0d: got %0d prev %0d ok=%0b want nonneg, nonincreasing after peak",
                         s, v, prev, ok);
            end
            if (v < prev) falling = 1'b1;
            prev = v;
        end
        n_cmp++;
        if (!falling || prev < 0 || prev > 16'sd1023) begin
            n_bad++; $display("FAIL decay_settle: got %0d falling=%0b want 0..1023 after decay", prev, falling);
        end
    endtask

    task automatic test_gain();
        logic signed [15:0] v;
        bit ok;
        mute_f = 1'b0;
        sin_f = 8'hFF; vol_f = 2'd3;
        apply_reset();
        wait_sample(v, ok);
        n_cmp++;
        if (!ok || v !== 16'sd32767) begin
            n_bad++; $display("FAIL gain_pos_sat: got %0d ok=%0b want 32767", v, ok);
        end
        sin_f = 8'hFF; vol_f = 2'd2;
        apply_reset();
        wait_sample(v, ok);
        n_cmp++;
        if (!ok || v !== 16'sd32512) begin
            n_bad++; $display("FAIL gain_x4: got %0d ok=%0b want 32512", v, ok);
        end
        sin_f = 8'hFF; vol_f = 2'd1;
        apply_reset();
        wait_sample(v, ok);
        n_cmp++;
        if (!ok || v !== 16'sd16256) begin
            n_bad++; $display("FAIL gain_x2: got %0d ok=%0b want 16256", v, ok);
        end
        sin_f = 8'h00; vol_f = 2'd3;
        apply_reset();
        wait_sample(v, ok);
        n_cmp++;
        if (!ok || v !== -16'sd32768) begin
            n_bad++; $display("FAIL gain_neg_sat: got %0d ok=%0b want -32768", v, ok);
        end
        sin_f = 8'h00; vol_f = 2'd0;
        apply_reset();
        wait_sample(v, ok);
        n_cmp++;
        if (!ok || v !== -16'sd8192) begin
            n_bad++; $display("FAIL gain_neg_x1: got %0d ok=%0b want -8192", v, ok);
        end
    endtask

    task automatic test_mute();
        logic signed [15:0] v;
        bit ok;
        sin_f = 8'hFF; vol_f = 2'd0; mute_f = 1'b1;
        apply_reset();
        wait_sample(v, ok);
        n_cmp++;
        if (!ok || v !== 16'sd0) begin
            n_bad++; $display("FAIL mute_s1: got %0d ok=%0b want 0", v, ok);
        end
        wait_sample(v, ok);
        n_cmp++;
        if (!ok || v !== 16'sd0) begin
            n_bad++; $display("FAIL mute_s2: got %0d ok=%0b want 0", v, ok);
        end
        mute_f = 1'b0;
        wait_sample(v, ok);
        n_cmp++;
        if (!ok || v !== 16'sd18774) begin
            n_bad++; $display("FAIL unmute_s3: got %0d ok=%0b want 18774", v, ok);
        end
    endtask

    task automatic test_reset_mid_sample();
        logic signed [15:0] v;
        bit ok, seen;
        int at;
        sin_f = 8'hFF; vol_f = 2'd0; mute_f = 1'b0;
        apply_reset();
        wait_sample(v, ok);
        n_cmp++;
        if (!ok || v !== 16'sd8128) begin
            n_bad++; $display("FAIL midrst_pre: got %0d ok=%0b want 8128", v, ok);
        end
        // Second capture is 4 edges after this strobe; reset lands 2 clocks after it
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (aout_f !== 16'sd0 || avalid_f !== 1'b0) begin
            n_bad++; $display("FAIL midrst_clear: aout=%0d avalid=%0b want 0/0", aout_f, avalid_f);
        end
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (avalid_f) seen = 1'b1;
        end
        n_cmp++;
        if (seen) begin
            n_bad++; $display("FAIL midrst_no_strobe: avalid seen=1 want 0");
        end
        rst_n = 1'b1;
        at = 0;
        v  = '0;
        for (int n = 1; n <= 20 && at == 0; n++) begin
            @(negedge clk);
            if (avalid_f) begin
                at = n;
                v  = aout_f;
            end
        end
        n_cmp++;
        if (at != 12 || v !== 16'sd8128) begin
            n_bad++; $display("FAIL midrst_next: strobe edge %0d value %0d want edge 12 value 8128", at, v);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        test_reset();
        test_sample_timing();
        test_step_and_decay();
        test_gain();
        test_mute();
        test_reset_mid_sample();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
